// File: rtl/branch_unit_pkg.sv
// Shared pipeline definitions for the branch unit: opcode and FSM state
// encodings plus the default flush length.
package branch_unit_pkg;

    // Branch opcodes as presented by the decode stage
    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_BEQ  = 3'd1,
        BR_BNE  = 3'd2,
        BR_BLEZ = 3'd3,
        BR_BGTZ = 3'd4,
        BR_BLTZ = 3'd5,
        BR_BGEZ = 3'd6
    } br_op_t;

    // Branch unit control states
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_SQUASH   = 2'd2
    } bu_state_t;

    // Default number of squash cycles after a taken branch (legal 1..7)
    localparam int DEFAULT_FLUSH_CYCLES = 2;

    // Width of the squash-cycle counter; holds values up to 7
    localparam int FLUSH_CNT_W = 3;

endpackage

// File: rtl/branch_unit_cond.sv
// Combinational branch condition evaluation. Operands are signed two's
// complement; rt only matters for BEQ and BNE.
module branch_cond
    import branch_unit_pkg::*;
(
    input  logic [2:0]  br_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        taken
);

    logic signed [31:0] rs_s;
    logic               rs_neg;
    logic               rs_zero;

    assign rs_s    = $signed(rs_val);
    assign rs_neg  = rs_s < 0;
    assign rs_zero = rs_val == 32'd0;

    // Decode the opcode into a taken/not-taken decision
    always_comb begin
        taken = 1'b0;
        case (br_op_t'(br_op))
            BR_BEQ:  taken = rs_val == rt_val;
            BR_BNE:  taken = rs_val != rt_val;
            BR_BLEZ: taken = rs_neg || rs_zero;
            BR_BGTZ: taken = !rs_neg && !rs_zero;
            BR_BLTZ: taken = rs_neg;
            BR_BGEZ: taken = !rs_neg;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_unit.sv
// Branch resolution unit: evaluates branches in the branch stage, issues a
// one-cycle fetch redirect for taken branches, squashes younger work for
// FLUSH_CYCLES cycles and keeps saturating performance counters.
// Handshake: a branch is consumed on a rising edge where in_valid=1,
// br_op!=NONE, stall=0 and the unit is IDLE; there is no ready output, so
// anything presented while redirecting/squashing is dropped by design.
module branch_unit
    import branch_unit_pkg::*;
#(
    parameter int FLUSH_CYCLES = DEFAULT_FLUSH_CYCLES,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [31:0]      pc_plus4,
    input  logic [31:0]      offset_sh,
    input  logic [31:0]      rs_val,
    input  logic [31:0]      rt_val,
    input  logic [2:0]       br_op,
    input  logic             stall,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             squash,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    localparam logic [FLUSH_CNT_W-1:0] FLUSH_LAST = FLUSH_CNT_W'(FLUSH_CYCLES);

    bu_state_t              state;
    logic [FLUSH_CNT_W-1:0] flush_cnt;
    logic                   taken;
    logic                   accept;
    logic [31:0]            target;

    branch_cond u_cond (
        .br_op  (br_op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .taken  (taken)
    );

    // Carry out of bit 31 is intentionally dropped
    assign target = pc_plus4 + offset_sh;
    assign accept = in_valid && (br_op != BR_NONE) && !stall && (state == ST_IDLE);

    // Control FSM: redirect pulse, squash window and latched target
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            flush_cnt      <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= 32'd0;
            squash         <= 1'b0;
        end else if (!stall) begin
            case (state)
                ST_IDLE: begin
                    if (accept && taken) begin
                        state          <= ST_REDIRECT;
                        flush_cnt      <= FLUSH_CNT_W'(1);
                        redirect_valid <= 1'b1;
                        redirect_pc    <= target;
                        squash         <= 1'b1;
                    end
                end
                ST_REDIRECT: begin
                    redirect_valid <= 1'b0;
                    if (flush_cnt < FLUSH_LAST) begin
                        state     <= ST_SQUASH;
                        flush_cnt <= flush_cnt + 1'b1;
                    end else begin
                        state     <= ST_IDLE;
                        flush_cnt <= '0;
                        squash    <= 1'b0;
                    end
                end
                ST_SQUASH: begin
                    if (flush_cnt < FLUSH_LAST) begin
                        flush_cnt <= flush_cnt + 1'b1;
                    end else begin
                        state     <= ST_IDLE;
                        flush_cnt <= '0;
                        squash    <= 1'b0;
                    end
                end
                default: begin
                    state          <= ST_IDLE;
                    flush_cnt      <= '0;
                    redirect_valid <= 1'b0;
                    squash         <= 1'b0;
                end
            endcase
        end
    end

    // Saturating performance counters, stepped only by accepted branches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt <= '0;
            taken_cnt  <= '0;
        end else if (accept) begin
            if (branch_cnt != {CNT_W{1'b1}})
                branch_cnt <= branch_cnt + 1'b1;
            if (taken && (taken_cnt != {CNT_W{1'b1}}))
                taken_cnt <= taken_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_branch_unit.sv
// Bench for branch_unit: directed vectors, redirect targets checked by a
// scoreboard monitor; a second narrow-counter instance covers saturation
// and the single-cycle flush configuration.
module tb_branch_unit;
    import branch_unit_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // main instance signals
    logic        in_valid, stall;
    logic [31:0] pc_plus4, offset_sh, rs_val, rt_val;
    logic [2:0]  br_op;
    logic        redirect_valid, squash;
    logic [31:0] redirect_pc;
    logic [15:0] branch_cnt, taken_cnt;

    // saturation instance signals
    logic        s_in_valid, s_stall;
    logic [31:0] s_pc_plus4, s_offset_sh, s_rs_val, s_rt_val;
    logic [2:0]  s_br_op;
    logic        s_redirect_valid, s_squash;
    logic [31:0] s_redirect_pc;
    logic [3:0]  s_branch_cnt, s_taken_cnt;

    branch_unit #(.FLUSH_CYCLES(2), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .pc_plus4(pc_plus4),
        .offset_sh(offset_sh), .rs_val(rs_val), .rt_val(rt_val), .br_op(br_op),
        .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .squash(squash), .branch_cnt(branch_cnt), .taken_cnt(taken_cnt)
    );

    branch_unit #(.FLUSH_CYCLES(1), .CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .pc_plus4(s_pc_plus4),
        .offset_sh(s_offset_sh), .rs_val(s_rs_val), .rt_val(s_rt_val), .br_op(s_br_op),
        .stall(s_stall), .redirect_valid(s_redirect_valid), .redirect_pc(s_redirect_pc),
        .squash(s_squash), .branch_cnt(s_branch_cnt), .taken_cnt(s_taken_cnt)
    );

    // ---------------- scoreboard ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];
    logic        prev_rv  = 1'b0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    // monitor: each new redirect pulse pops one expected target
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_rv = 1'b0;
        end else begin
            if (redirect_valid && !prev_rv) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_redirect: actual pc 0x%08h required no redirect", redirect_pc);
                end else begin
                    check32("redirect_pc", redirect_pc, exp_q.pop_front());
                end
            end
            prev_rv = redirect_valid;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                         input logic [31:0] pc4, input logic [31:0] off,
                         input logic exp_taken, input logic [31:0] exp_pc);
        in_valid  = 1'b1;
        br_op     = op;
        rs_val    = rs;
        rt_val    = rt;
        pc_plus4  = pc4;
        offset_sh = off;
        if (exp_taken) exp_q.push_back(exp_pc);
        step();
        in_valid = 1'b0;
        br_op    = BR_NONE;
        check32("redirect_valid_n1", 32'(redirect_valid), 32'(exp_taken));
        check32("squash_n1", 32'(squash), 32'(exp_taken));
    endtask

    // count cycles with squash high until it drops (bounded)
    task automatic drain(input string name, input int exp_len);
        int n = 0;
        while (squash === 1'b1 && n < 16) begin
            n++;
            step();
        end
        check32(name, 32'(n), 32'(exp_len));
    endtask

    task automatic expect_cnt(input string name, input int b, input int t);
        check32({name, "_branch_cnt"}, 32'(branch_cnt), 32'(b));
        check32({name, "_taken_cnt"}, 32'(taken_cnt), 32'(t));
    endtask

    // directed table: op, rs, rt, pc4, off, taken, target
    typedef struct {
        logic [2:0]  op;
        logic [31:0] rs, rt, pc4, off;
        logic        tk;
        logic [31:0] tgt;
    } vec_t;

    vec_t vecs[9];

    // ---------------- stimulus ----------------
    initial begin
        vecs[0] = '{BR_BLEZ, 32'h0000_0000, 32'd123,       32'h0000_0100, 32'h0000_0020, 1'b1, 32'h0000_0120};
        vecs[1] = '{BR_BGEZ, 32'h8000_0000, 32'd0,         32'h0000_0200, 32'h0000_0020, 1'b0, 32'h0};
        vecs[2] = '{BR_BEQ,  32'd1,         32'd2,         32'h0000_0300, 32'h0000_0020, 1'b0, 32'h0};
        vecs[3] = '{BR_BNE,  32'd1,         32'd2,         32'h0000_2000, 32'hFFFF_FF00, 1'b1, 32'h0000_1F00};
        vecs[4] = '{BR_BGTZ, 32'd1,         32'd0,         32'h7FFF_FFFC, 32'h0000_0008, 1'b1, 32'h8000_0004};
        vecs[5] = '{BR_BLEZ, 32'd1,         32'd0,         32'h0000_0400, 32'h0000_0020, 1'b0, 32'h0};
        vecs[6] = '{BR_BLTZ, 32'd0,         32'd0,         32'h0000_0500, 32'h0000_0020, 1'b0, 32'h0};
        vecs[7] = '{BR_BGEZ, 32'd0,         32'd9,         32'h0000_0040, 32'h0000_0040, 1'b1, 32'h0000_0080};
        vecs[8] = '{BR_BEQ,  32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFF0, 32'h0000_0020, 1'b1, 32'h0000_0010};

        rst_n = 1'b0; in_valid = 1'b0; stall = 1'b0; br_op = BR_NONE;
        pc_plus4 = '0; offset_sh = '0; rs_val = '0; rt_val = '0;
        s_in_valid = 1'b0; s_stall = 1'b0; s_br_op = BR_NONE;
        s_pc_plus4 = '0; s_offset_sh = '0; s_rs_val = '0; s_rt_val = '0;
        step();
        step();

        // reset state
        check32("rst_redirect_valid", 32'(redirect_valid), 32'd0);
        check32("rst_redirect_pc", redirect_pc, 32'd0);
        check32("rst_squash", 32'(squash), 32'd0);
        expect_cnt("rst", 0, 0);

        // first edge after release accepts: BEQ taken
        rst_n = 1'b1;
        issue(BR_BEQ, 32'd5, 32'd5, 32'h0000_1004, 32'h0000_0010, 1'b1, 32'h0000_1014);
        check32("beq_pc_direct", redirect_pc, 32'h0000_1014);
        drain("beq_squash_len", 2);
        expect_cnt("beq", 1, 1);

        // BNE equal operands: not taken
        issue(BR_BNE, 32'd7, 32'd7, 32'h0000_1004, 32'h0000_0010, 1'b0, 32'h0);
        drain("bne_squash_len", 0);
        expect_cnt("bne", 2, 1);

        // BLTZ with target wrap
        issue(BR_BLTZ, 32'hFFFF_FFFF, 32'd0, 32'h0000_0008, 32'hFFFF_FFF8, 1'b1, 32'h0000_0000);
        drain("bltz_squash_len", 2);
        // BGTZ most negative: not taken
        issue(BR_BGTZ, 32'h8000_0000, 32'd0, 32'h0000_0008, 32'h0000_0010, 1'b0, 32'h0);
        expect_cnt("bltz_bgtz", 4, 2);
        // redirect_pc holds last target while idle
        check32("pc_hold", redirect_pc, 32'h0000_0000);

        // table of opcode/operand corner cases: 9 accepted, 5 taken
        for (int i = 0; i < 9; i++) begin
            issue(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].pc4, vecs[i].off,
                  vecs[i].tk, vecs[i].tgt);
            drain("table_squash_len", vecs[i].tk ? 2 : 0);
        end
        expect_cnt("table", 13, 7);

        // non-accepted inputs: NONE opcode, in_valid low, stalled
        in_valid = 1'b1; br_op = BR_NONE; rs_val = 32'd5; rt_val = 32'd5;
        step();
        in_valid = 1'b0; br_op = BR_BEQ;
        step();
        in_valid = 1'b1; stall = 1'b1;
        step();
        check32("stall_idle_rv", 32'(redirect_valid), 32'd0);
        in_valid = 1'b0; stall = 1'b0; br_op = BR_NONE;
        step();
        expect_cnt("rejected", 13, 7);

        // branches arriving during REDIRECT/SQUASH are dropped
        issue(BR_BEQ, 32'd3, 32'd3, 32'h0000_3000, 32'h0000_0004, 1'b1, 32'h0000_3004);
        in_valid = 1'b1; br_op = BR_BEQ; pc_plus4 = 32'h0000_9000;
        step();
        check32("squash_during_sq", 32'(squash), 32'd1);
        step();
        check32("squash_end_sq", 32'(squash), 32'd0);
        in_valid = 1'b0; br_op = BR_NONE;
        step();
        expect_cnt("squashed_work", 14, 8);

        // stall held in REDIRECT for three cycles
        issue(BR_BNE, 32'd0, 32'd1, 32'h0000_5000, 32'h0000_0100, 1'b1, 32'h0000_5100);
        stall = 1'b1; in_valid = 1'b1; br_op = BR_BEQ; rs_val = 32'd0; rt_val = 32'd0;
        for (int i = 0; i < 3; i++) begin
            step();
            check32("stall_rv_held", 32'(redirect_valid), 32'd1);
            check32("stall_pc_held", redirect_pc, 32'h0000_5100);
        end
        stall = 1'b0; in_valid = 1'b0; br_op = BR_NONE;
        step();
        check32("post_stall_rv", 32'(redirect_valid), 32'd0);
        check32("post_stall_squash", 32'(squash), 32'd1);
        step();
        check32("post_stall_done", 32'(squash), 32'd0);
        expect_cnt("stall", 15, 9);

        // reset pulse during SQUASH
        issue(BR_BGEZ, 32'd5, 32'd0, 32'h0000_6000, 32'h0000_0010, 1'b1, 32'h0000_6010);
        step();
        check32("pre_rst_squash", 32'(squash), 32'd1);
        rst_n = 1'b0;
        #1;
        check32("midrst_squash", 32'(squash), 32'd0);
        check32("midrst_rv", 32'(redirect_valid), 32'd0);
        check32("midrst_pc", redirect_pc, 32'd0);
        expect_cnt("midrst", 0, 0);
        step();
        rst_n = 1'b1;
        check32("after_rst_squash", 32'(squash), 32'd0);
        issue(BR_BEQ, 32'd9, 32'd9, 32'h0000_7000, 32'hFFFF_F000, 1'b1, 32'h0000_6000);
        drain("after_rst_squash_len", 2);
        expect_cnt("after_rst", 1, 1);

        // saturation instance: 4-bit counters, one-cycle flush
        s_br_op = BR_BEQ; s_rs_val = 32'd0; s_rt_val = 32'd0; s_offset_sh = 32'h0000_0100;
        for (int i = 0; i < 16; i++) begin
            s_in_valid = 1'b1;
            s_pc_plus4 = 32'(i * 4);
            step();
            s_in_valid = 1'b0;
            check32("sat_rv", 32'(s_redirect_valid), 32'd1);
            check32("sat_pc", s_redirect_pc, 32'(i * 4 + 256));
            step();
            check32("sat_flush1_squash", 32'(s_squash), 32'd0);
            if (i == 14) check32("sat_taken_15", 32'(s_taken_cnt), 32'd15);
        end
        check32("sat_taken_hold", 32'(s_taken_cnt), 32'd15);
        check32("sat_branch_hold", 32'(s_branch_cnt), 32'd15);
        s_br_op = BR_BNE; s_in_valid = 1'b1;
        step();
        s_in_valid = 1'b0;
        check32("sat_nt_rv", 32'(s_redirect_valid), 32'd0);
        check32("sat_nt_branch", 32'(s_branch_cnt), 32'd15);

        // every expected redirect must have been observed
        step();
        check32("sb_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/branch_unit.md
BRANCH_UNIT -- requirements
Module: branch_unit

Interface
REQ-001 Parameter FLUSH_CYCLES, default 2, number of cycles the squash signal is held after a taken branch (legal range 1..7).
REQ-002 Parameter CNT_W, default 16, width of the performance counters.
REQ-003 clk  input  1  sole clock, all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert and active-low.
REQ-005 in_valid  input  1  branch-stage slot holds a valid instruction this cycle.
REQ-006 pc_plus4  input  32  PC+4 of the slot instruction, cycle-aligned with offset_sh.
REQ-007 offset_sh  input  32  sign-extended immediate already shifted left by 2, from the registered shift stage.
REQ-008 rs_val  input  32  first compare operand, signed two's complement.
REQ-009 rt_val  input  32  second compare operand, signed two's complement.
REQ-010 br_op  input  3  branch opcode: NONE, BEQ, BNE, BLEZ, BGTZ, BLTZ, BGEZ.
REQ-011 stall  input  1  pipeline stall; freezes all block state.
REQ-012 redirect_valid  output  1  one-cycle pulse requesting a fetch redirect.
REQ-013 redirect_pc  output  32  target address, meaningful only while redirect_valid = 1.
REQ-014 squash  output  1  kill the younger instructions in IF/ID.
REQ-015 branch_cnt  output  CNT_W  count of evaluated branches, saturating.
REQ-016 taken_cnt  output  CNT_W  count of taken branches, saturating.

Function
REQ-017 A branch SHALL be accepted in a cycle where in_valid=1, br_op!=NONE, stall=0, and the FSM is IDLE.
REQ-018 Conditions SHALL be: BEQ rs==rt; BNE rs!=rt; BLEZ rs<=0; BGTZ rs>0; BLTZ rs<0; BGEZ rs>=0. All signed; rt is ignored except for BEQ and BNE.
REQ-019 Target SHALL be pc_plus4+offset_sh, computed modulo 2^32 with the carry discarded.
REQ-020 The FSM SHALL have three states: IDLE, REDIRECT and SQUASH.
REQ-021 IDLE -> REDIRECT on an accepted taken branch. IDLE -> IDLE on a not-taken branch or when no branch is accepted.
REQ-022 REDIRECT SHALL last exactly one cycle, with redirect_valid=1, redirect_pc=latched target, squash=1. It then moves to SQUASH if FLUSH_CYCLES>1, otherwise to IDLE.
REQ-023 SQUASH SHALL hold squash=1 until a total of FLUSH_CYCLES squash cycles, counting the REDIRECT cycle, have elapsed. It then returns to IDLE.
REQ-024 Latency: a taken branch accepted at edge N SHALL give redirect_valid=1 in cycle N+1.
REQ-025 Branch inputs arriving in REDIRECT or SQUASH are squashed work. They SHALL be ignored and SHALL NOT be counted.
REQ-026 Accepted branch: branch_cnt increments by 1; it also increments taken_cnt by 1 when the branch is taken. Both counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-027 stall=1 SHALL freeze the FSM state, the squash-cycle counter, both perf counters and all outputs. The current output values are held and no branch is accepted.
REQ-028 The block SHALL NOT accept any branch when br_op=NONE or in_valid=0, regardless of the other inputs.
REQ-029 redirect_pc SHALL hold its last value when redirect_valid=0.

Reset
REQ-030 rst_n=0 SHALL immediately force: FSM=IDLE, redirect_valid=0, redirect_pc=0, squash=0, branch_cnt=0, taken_cnt=0, squash counter=0.
REQ-031 Reset asserted during REDIRECT or SQUASH SHALL abort the flush with no residual pulse after release.
REQ-032 After rst_n deasserts, the first rising edge SHALL be able to accept a branch.

Structure
REQ-033 The br_op encodings (NONE=0 through BGEZ=6), the FSM state encodings and the default FLUSH_CYCLES SHALL live in a shared pipeline package.
REQ-034 Condition evaluation SHALL be a separate combinational sub-module, branch_cond (inputs br_op, rs_val, rt_val; output taken).
REQ-035 All outputs SHALL be driven directly from registers.

Verification
REQ-036 BEQ, rs=rt=5, pc_plus4=0x0000_1004, offset_sh=0x0000_0010 -> cycle N+1 redirect_valid=1, redirect_pc=0x0000_1014; squash high 2 cycles; branch_cnt=1, taken_cnt=1.
REQ-037 BNE, rs=rt=7 -> no redirect, squash=0; branch_cnt=1, taken_cnt=0.
REQ-038 BLTZ, rs=0xFFFF_FFFF, pc_plus4=0x0000_0008, offset_sh=0xFFFF_FFF8 -> redirect_pc=0x0000_0000 (wrap). BGTZ, rs=0x8000_0000 -> not taken.
REQ-039 Taken branch, then back-to-back valid branches during SQUASH -> the later branches are ignored and branch_cnt is unchanged. stall=1 in REDIRECT for 3 cycles -> redirect_valid held for 3 cycles, then squash continues.
REQ-040 rst_n pulsed low during SQUASH -> squash=0 and counters=0 immediately; the next taken branch redirects normally.
REQ-041 Preload, or drive 65535 taken branches -> taken_cnt=0xFFFF; one more taken branch -> taken_cnt stays 0xFFFF.
